// File: rtl/countdown_timer.sv
// Loadable seconds countdown timer: divides clock by cycles_per_second and counts Q down to zero.
// Optional auto-reload on expiry is enabled by defining COUNTDOWN_TIMER_AUTO_RELOAD_EN.
module countdown_timer #(
   parameter int cycles_per_second = 25000000,
   parameter int WIDTH             = 8
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             count,
   output logic [WIDTH-1:0] Q,
   output logic             tick,
   output logic             done,
   output logic             running,
   output logic             expired
);

   localparam int PW = (cycles_per_second > 1) ? $clog2(cycles_per_second) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(cycles_per_second - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_EXPIRED = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic             tick_q, tick_d;
   logic             done_q, done_d;
   logic             running_q, running_d;
   logic             expired_q, expired_d;

   logic             sec_end_s;
   logic             final_sec_s;
   logic             step_s;
   logic             rearm_s;
   logic [WIDTH-1:0] rearm_val_s;

   assign sec_end_s   = (presc_q == PRESC_LAST);
   assign final_sec_s = (q_q == WIDTH'(1));
   assign step_s      = (state_q == ST_RUNNING) && count && !load;

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload_q, reload_d;

   // Start value remembered for rearming after each expiry.
   always_comb begin
      if (load) begin
         reload_d = load_value;
      end else begin
         reload_d = reload_q;
      end
   end

   // Reload register.
   always_ff @(posedge clock) begin
      if (clear) begin
         reload_q <= '0;
      end else begin
         reload_q <= reload_d;
      end
   end

   assign rearm_s     = (reload_q != '0);
   assign rearm_val_s = reload_q;
`else
   assign rearm_s     = 1'b0;
   assign rearm_val_s = '0;
`endif

   // State register.
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; load is accepted from every state.
   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = (load_value != '0) ? ST_RUNNING : ST_EXPIRED;
      end else if (step_s && sec_end_s && final_sec_s && !rearm_s) begin
         state_d = ST_EXPIRED;
      end else begin
         state_d = state_q;
      end
   end

   // Datapath and flag values for the next edge.
   always_comb begin
      q_d     = q_q;
      presc_d = presc_q;
      tick_d  = 1'b0;
      done_d  = 1'b0;
      if (load) begin
         q_d     = load_value;
         presc_d = '0;
      end else if (step_s) begin
         if (sec_end_s) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (final_sec_s) begin
               done_d = 1'b1;
               q_d    = rearm_s ? rearm_val_s : '0;
            end else begin
               q_d = q_q - WIDTH'(1);
            end
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end else begin
         q_d     = q_q;
         presc_d = presc_q;
      end
      running_d = (state_d == ST_RUNNING);
      expired_d = (state_d == ST_EXPIRED);
   end

   // Datapath and output registers.
   always_ff @(posedge clock) begin
      if (clear) begin
         q_q       <= '0;
         presc_q   <= '0;
         tick_q    <= 1'b0;
         done_q    <= 1'b0;
         running_q <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         q_q       <= q_d;
         presc_q   <= presc_d;
         tick_q    <= tick_d;
         done_q    <= done_d;
         running_q <= running_d;
         expired_q <= expired_d;
      end
   end

   assign Q       = q_q;
   assign tick    = tick_q;
   assign done    = done_q;
   assign running = running_q;
   assign expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random traffic against
// an elapsed-time reference model. Honours COUNTDOWN_TIMER_AUTO_RELOAD_EN when defined.
module tb_countdown_timer;

   localparam int CPS   = 10;
   localparam int WIDTH = 8;

   logic             clock;
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             count;
   logic [WIDTH-1:0] Q;
   logic             tick;
   logic             done;
   logic             running;
   logic             expired;

   int n_tests;
   int n_fail;
   int cyc;
   int tick_cnt;
   int done_cnt;
   int first_tick;
   int first_done;
   bit exp_seen;
   int mark;

   // Reference model: mode 0 idle, 1 running, 2 expired; el counts enabled cycles since load.
   int m_mode;
   int m_lv;
   int m_el;
   bit m_tick;
   bit m_done;

   countdown_timer #(
      .cycles_per_second(CPS),
      .WIDTH            (WIDTH)
   ) dut (
      .clock     (clock),
      .clear     (clear),
      .load      (load),
      .load_value(load_value),
      .count     (count),
      .Q         (Q),
      .tick      (tick),
      .done      (done),
      .running   (running),
      .expired   (expired)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         if (n_fail <= 40) begin
            $display("FAIL %s cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
         end
      end
   endtask

   function automatic int model_q();
      int n;
      n = m_el / CPS;
      if (m_mode != 1) return 0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      return m_lv - (n % m_lv);
`else
      return m_lv - n;
`endif
   endfunction

   task automatic model_edge(input bit clr, input bit ld, input int lv, input bit cnt);
      int n;
      m_tick = 1'b0;
      m_done = 1'b0;
      if (clr) begin
         m_mode = 0;
         m_lv   = 0;
         m_el   = 0;
      end else if (ld) begin
         m_lv   = lv;
         m_el   = 0;
         m_mode = (lv != 0) ? 1 : 2;
      end else if (m_mode == 1 && cnt) begin
         m_el++;
         if (m_el % CPS == 0) begin
            m_tick = 1'b1;
            n = m_el / CPS;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
            m_done = (n % m_lv == 0);
`else
            if (n == m_lv) begin
               m_done = 1'b1;
               m_mode = 2;
            end
`endif
         end
      end
   endtask

   task automatic step(input bit clr, input bit ld, input int lv, input bit cnt);
      clear      = clr;
      load       = ld;
      load_value = WIDTH'(lv);
      count      = cnt;
      @(posedge clock);
      model_edge(clr, ld, lv, cnt);
      #1;
      cyc++;
      check("Q", 32'(Q), 32'(model_q()));
      check("tick", 32'(tick), 32'(m_tick));
      check("done", 32'(done), 32'(m_done));
      check("running", 32'(running), 32'(m_mode == 1));
      check("expired", 32'(expired), 32'(m_mode == 2));
      if (tick) begin
         tick_cnt++;
         if (first_tick < 0) first_tick = cyc;
      end
      if (done) begin
         done_cnt++;
         if (first_done < 0) first_done = cyc;
      end
      if (expired) exp_seen = 1'b1;
   endtask

   task automatic clear_marks();
      tick_cnt   = 0;
      done_cnt   = 0;
      first_tick = -1;
      first_done = -1;
      exp_seen   = 1'b0;
      mark       = cyc;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      cyc     = 0;
      m_mode  = 0;
      m_lv    = 0;
      m_el    = 0;
      m_tick  = 1'b0;
      m_done  = 1'b0;
      clear      = 1'b1;
      load       = 1'b0;
      load_value = '0;
      count      = 1'b0;

      // Reset, then counting enabled in IDLE must do nothing.
      step(1'b1, 1'b0, 0, 1'b0);
      step(1'b1, 1'b0, 0, 1'b0);
      clear_marks();
      for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 0, 1'b1);
      check("idle_ticks", 32'(tick_cnt), 32'd0);
      check("idle_q", 32'(Q), 32'd0);

      // Basic countdown from 3.
      step(1'b0, 1'b1, 3, 1'b1);
      clear_marks();
      for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 0, 1'b1);
      check("basic_first_tick", 32'(first_tick - mark), 32'd10);
      check("basic_ticks", 32'(tick_cnt), 32'd3);
      check("basic_dones", 32'(done_cnt), 32'd1);
      check("basic_done_at", 32'(first_done - mark), 32'd30);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0, 1'b1);

      // Pause keeps prescaler progress.
      step(1'b0, 1'b1, 2, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0, 1'b1);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 0, 1'b0);
      clear_marks();
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 0, 1'b1);
      check("pause_first_tick", 32'(first_tick - mark), 32'd5);
      check("pause_done_at", 32'(first_done - mark), 32'd15);

      // Load on the cycle a tick is due.
      step(1'b0, 1'b1, 2, 1'b1);
      for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 0, 1'b1);
      step(1'b0, 1'b1, 9, 1'b1);
      check("prio_load_tick", 32'(tick), 32'd0);
      check("prio_load_q", 32'(Q), 32'd9);
      // Clear and load together.
      step(1'b1, 1'b1, 7, 1'b1);
      check("prio_clear_q", 32'(Q), 32'd0);
      check("prio_clear_run", 32'(running), 32'd0);

      // Load zero goes straight to EXPIRED, then reload 1.
      step(1'b0, 1'b1, 0, 1'b1);
      check("zero_expired", 32'(expired), 32'd1);
      check("zero_done", 32'(done), 32'd0);
      step(1'b0, 1'b0, 0, 1'b1);
      step(1'b0, 1'b1, 1, 1'b1);
      clear_marks();
      for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 0, 1'b1);
      check("one_done_at", 32'(first_done - mark), 32'd10);

      // Long run from 2: periodic with auto-reload, one-shot otherwise.
      step(1'b0, 1'b1, 2, 1'b1);
      clear_marks();
      for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 0, 1'b1);
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      check("auto_dones", 32'(done_cnt), 32'd3);
      check("auto_expired", 32'(exp_seen), 32'd0);
`else
      check("oneshot_dones", 32'(done_cnt), 32'd1);
      check("oneshot_expired", 32'(exp_seen), 32'd1);
`endif
      check("long_first_done", 32'(first_done - mark), 32'd20);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 63) == 0),
              ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 4)),
              ($urandom_range(0, 3) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable 8-bit seconds countdown timer. It is the down-counting counterpart of the team's free-running seconds `counter` and uses the same `clock`/`clear`/`count` port conventions. It divides `clock` by `cycles_per_second` and decrements `Q` once per second from a loaded value to zero, then signals expiry. It sits beside `counter` in the timing/status logic and drives timeouts and on-screen countdowns.

## Interface
- `cycles_per_second`, default 25000000: clock cycles per one-second tick; must be ≥ 2.
- `WIDTH`, default 8: width of `Q` and `load_value`.
- `clock` in 1: single clock; all state updates on its rising edge.
- `clear` in 1: reset, synchronous and active-high; wins over every other input.
- `load` in 1: one-cycle load strobe, sampled each rising edge.
- `load_value` in WIDTH: start value, captured when `load`=1.
- `count` in 1: count enable; 0 pauses the prescaler and `Q`.
- `Q` out WIDTH: remaining seconds.
- `tick` out 1: one-cycle pulse on each decrement of `Q`.
- `done` out 1: one-cycle pulse in the cycle `Q` reaches 0 by counting.
- `running` out 1: high in RUNNING.
- `expired` out 1: high in EXPIRED.

## Operation
- State machine: IDLE, RUNNING, EXPIRED. All outputs are registered.
- Internal registers: `reload` (WIDTH) and a prescaler sized ceil(log2(cycles_per_second)).
- `clear`=1 forces the following on that edge: state=IDLE; `Q`=0; `reload`=0; prescaler=0; `tick`=`done`=`running`=`expired`=0.
- `load`=1 is accepted in any state and takes priority over `count` and ticks. On load:
  - `Q`=`load_value`, `reload`=`load_value`, prescaler=0.
  - State becomes RUNNING if `load_value`≠0, otherwise EXPIRED, with no `done` pulse.
- RUNNING with `count`=1: the prescaler increments. When it equals `cycles_per_second`-1, it wraps to 0, `tick` pulses, and `Q` decrements.
- RUNNING with `count`=0: the prescaler and `Q` hold. No progress is lost across a pause.
- When a decrement takes `Q` from 1 to 0: `done`=1 in the same cycle and state becomes EXPIRED. `tick` also pulses in that cycle.
- EXPIRED: `Q` holds 0 and `count` is ignored. The state is left only by `load` or `clear`.
- IDLE: `Q`=0 and `count` is ignored. The state is left only by `load`.
- Arithmetic: unsigned. `Q` never wraps below 0, because no decrement is issued at 0.

## Timing
- Load on edge k gives `Q`=`load_value` after edge k.
- With `count` held 1 from edge k, the n-th decrement happens at edge k+n·`cycles_per_second`.
- `done` and `expired` become high after edge k+`load_value`·`cycles_per_second`.
- `tick` and `done` are each exactly one cycle wide.
- `load` in the same cycle as a would-be tick: the load wins, and no tick or done is produced.
- `clear` mid-count: IDLE on the next edge. Prescaler progress is discarded.

## Configuration
- Macro: `COUNTDOWN_TIMER_AUTO_RELOAD_EN`.
- Defined:
  - On reaching 0, `Q` is reloaded from `reload` in the same edge that pulses `done`.
  - The state stays RUNNING, so `Q` never shows 0 and `expired` never rises from counting.
  - If `reload`=0, behaviour is as in the undefined case.
- Undefined: one-shot behaviour as described in Operation. The `reload` register may be optimised away.

## Test plan
All scenarios use `cycles_per_second`=10.
- Reset: `clear`=1 for 2 cycles, then 0 → `Q`=0, state IDLE, all flags 0; `count`=1 for 50 cycles → `Q` stays 0, no `tick`.
- Basic countdown:
  - Stimulus: `load`, `load_value`=3, `count`=1.
  - Required: `tick` after edges +10, +20, +30; `Q` goes 3→2→1→0.
  - Required: `done` for exactly one cycle, coincident with the third `tick`; `expired`=1 afterwards.
- Pause:
  - Stimulus: load 2, `count`=1 for 5 cycles, 0 for 20 cycles, then 1.
  - Required: first `tick` 5 cycles after resuming; `done` 10 cycles later.
- Priority:
  - Stimulus 1: `load`=1 with `load_value`=9 on the cycle a tick is due → `Q`=9, no `tick`.
  - Stimulus 2: `clear` and `load` together → IDLE, `Q`=0.
- Load zero and reload from EXPIRED:
  - Stimulus: `load_value`=0.
  - Required: `expired`=1, `done`=0.
  - Required: a subsequent load of 1 gives `done` after 10 cycles.
- Auto-reload, with `COUNTDOWN_TIMER_AUTO_RELOAD_EN` defined:
  - Stimulus: load 2, `count`=1 for 60 cycles.
  - Required: `Q` sequence 2,1,2,1,2,1.
  - Required: `done` pulses at cycles +20, +40, +60; `expired` never set.
